// File: rtl/enhance_frame_ctrl.sv
// Two-pass frame sequencer: pass 1 finds the frame peak, pass 2 streams pixels through
// the enhancement datapath with a gain derived from that peak and collects the writes.
module enhance_frame_ctrl #(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_R,
  input  logic [7:0]        rd_G,
  input  logic [7:0]        rd_B,
  output logic              dp_valid,
  output logic [2:0]        gain_shift,
  input  logic              res_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        frame_max,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int N  = IMG_W * IMG_H;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   LAST_WR = (ADDR_W + 1)'(N - 1);
  localparam logic [TW-1:0]     IDLE_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STATS, S_STATS_WAIT, S_CALC, S_ENHANCE, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic            cap;
  logic [ADDR_W:0] wr_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [7:0]      pix_max, new_max;
  logic [2:0]      lzc;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign wr_en   = res_valid && (state == S_ENHANCE || state == S_DRAIN);
  assign wr_addr = wr_cnt[ADDR_W-1:0];

  always_comb begin
    pix_max = rd_R;
    if (rd_G > pix_max) pix_max = rd_G;
    if (rd_B > pix_max) pix_max = rd_B;
    new_max = (pix_max > frame_max) ? pix_max : frame_max;
  end

  // Highest set bit wins; an all-zero peak leaves the gain at 0.
  always_comb begin
    lzc = 3'd0;
    for (int i = 0; i < 8; i++)
      if (frame_max[i]) lzc = 3'(7 - i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      cap        <= 1'b0;
      dp_valid   <= 1'b0;
      gain_shift <= 3'd0;
      frame_max  <= 8'd0;
      wr_cnt     <= '0;
      idle_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      cap      <= rd_en && (state == S_STATS) && !abort;
      dp_valid <= rd_en && (state == S_ENHANCE) && !abort;
      if (cap) frame_max <= new_max;

      case (state)
        S_IDLE: if (start) begin
          state      <= S_STATS;
          rd_en      <= 1'b1;
          rd_addr    <= '0;
          frame_max  <= 8'd0;
          gain_shift <= 3'd0;
          wr_cnt     <= '0;
          idle_cnt   <= '0;
          err        <= 1'b0;
        end
        S_STATS: if (rd_addr == LAST_RD) begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
          state   <= S_STATS_WAIT;
        end else rd_addr <= rd_addr + 1'b1;
        S_STATS_WAIT: state <= S_CALC;
        S_CALC: begin
          gain_shift <= lzc;
          rd_en      <= 1'b1;
          rd_addr    <= '0;
          state      <= S_ENHANCE;
        end
        S_ENHANCE: begin
          idle_cnt <= '0;
          if (rd_addr == LAST_RD) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            state   <= S_DRAIN;
          end else rd_addr <= rd_addr + 1'b1;
        end
        S_DRAIN:
          if (res_valid) idle_cnt <= '0;
          else if (idle_cnt == IDLE_LIM) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else idle_cnt <= idle_cnt + 1'b1;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // The final write completes the frame even if reads are still in flight.
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_WR) begin
          state <= S_DONE;
          rd_en <= 1'b0;
        end
      end

      if (abort && state != S_IDLE) begin
        state    <= S_IDLE;
        rd_en    <= 1'b0;
        dp_valid <= 1'b0;
        cap      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_enhance_frame_ctrl.sv
// Randomized frame-level bench: frame buffer and fixed-latency datapath models drive
// the sequencer; peak, gain, write order, frame time and error paths are checked.
module tb_enhance_frame_ctrl;
  localparam int N  = 256;
  localparam int TO = 16;

  logic       clk = 0, rst = 0, start = 0, abort = 0;
  logic       rd_en, dp_valid, res_valid, wr_en, busy, done, err;
  logic [7:0] rd_addr, wr_addr, frame_max;
  logic [7:0] rd_R = 0, rd_G = 0, rd_B = 0;
  logic [2:0] gain_shift;

  logic [23:0] mem [N];
  logic [7:0]  lp = 0;
  int          lat = 3;
  bit          kill = 0;
  int          n_chk = 0, n_err = 0;

  enhance_frame_ctrl #(.IMG_W(16), .IMG_H(16), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_R(rd_R), .rd_G(rd_G), .rd_B(rd_B),
    .dp_valid(dp_valid), .gain_shift(gain_shift), .res_valid(res_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .frame_max(frame_max),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Frame buffer with 1-cycle read latency; datapath as a pure delay of dp_valid.
  always @(posedge clk) begin
    if (rd_en) {rd_R, rd_G, rd_B} <= mem[rd_addr];
    lp <= {lp[6:0], dp_valid};
  end
  assign res_valid = lp[lat-1] & ~kill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_max();
    logic [7:0] m = 0;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < 3; c++) begin
        logic [7:0] v = 8'(mem[i] >> (8 * c));
        if (v > m) m = v;
      end
    return m;
  endfunction

  function automatic logic [2:0] ref_gain(input logic [7:0] p);
    int s = 0;
    if (p == 0) return 3'd0;
    while (p < 8'h80) begin p = p << 1; s++; end
    return 3'(s);
  endfunction

  task automatic fill(input logic [7:0] peak);
    int a;
    for (int i = 0; i < N; i++)
      mem[i] = {8'($urandom_range(peak, 0)), 8'($urandom_range(peak, 0)), 8'($urandom_range(peak, 0))};
    a = $urandom_range(N - 1, 0);
    mem[a] = mem[a] | (24'(peak) << (8 * $urandom_range(2, 0)));
  endtask

  task automatic run_frame(input int l, input bit poke);
    int cyc = 1, nwr = 0;
    bit seen = 0;
    lat = l;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_busy", busy, 1);
    check("start_rd", {rd_en, rd_addr}, {1'b1, 8'h00});
    check("start_err_clr", err, 0);
    while (!seen && cyc < 3000) begin
      start = poke && (cyc == 10);
      if (wr_en) begin check("wr_addr", wr_addr, nwr); nwr++; end
      if (done) seen = 1;
      else begin @(negedge clk); cyc++; end
    end
    start = 0;
    check("done_seen", seen, 1);
    check("frame_time", cyc - 1, 2 * N + 3 + l);
    check("n_writes", nwr, N);
    check("frame_max", frame_max, ref_max());
    check("gain_shift", gain_shift, ref_gain(ref_max()));
    if (poke) start = 1;
    @(negedge clk);
    start = 0;
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    repeat (3) @(negedge clk);
    check("no_restart", {busy, rd_en}, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 24'h101010;
    repeat (3) @(negedge clk);
    check("rst_outs", {rd_en, rd_addr, dp_valid, gain_shift, wr_en, wr_addr, frame_max, busy, done, err}, 0);
    rst = 1;
    @(negedge clk);

    // Uniform 0x10 frame, latency 3
    run_frame(3, 0);
    check("t1_max", frame_max, 8'h10);
    check("t1_gain", gain_shift, 3'd3);

    // Peak sweep with random latencies
    begin
      logic [7:0] pk [5] = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'hFF};
      logic [2:0] gx [5] = '{3'd0, 3'd7, 3'd0, 3'd1, 3'd0};
      for (int k = 0; k < 5; k++) begin
        fill(pk[k]);
        run_frame($urandom_range(6, 1), 0);
        check("sweep_gain", gain_shift, gx[k]);
      end
    end

    // start poked in STATS and in the DONE cycle
    fill(8'($urandom_range(255, 0)));
    run_frame($urandom_range(6, 1), 1);

    // Async reset mid-ENHANCE at rd_addr 0x40
    begin
      int cyc = 1;
      fill(8'($urandom_range(255, 1)));
      lat = 4;
      start = 1;
      @(negedge clk);
      start = 0;
      while (!(cyc > N + 2 && rd_en && rd_addr == 8'h40) && cyc < 2000) begin
        @(negedge clk); cyc++;
      end
      check("rst_reach_40", cyc, N + 3 + 8'h40);
      rst = 0;
      #1;
      check("rst_mid", {rd_en, rd_addr, dp_valid, gain_shift, wr_en, wr_addr, frame_max, busy, done, err}, 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      fill(8'($urandom_range(255, 0)));
      run_frame($urandom_range(6, 1), 0);
    end

    // Drain timeout with datapath stuck
    begin
      int cyc = 1, nd = 0, nw = 0;
      kill = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      while (!err && cyc < 2000) begin
        @(negedge clk); cyc++;
        nd += done; nw += wr_en;
      end
      check("to_time", cyc, 2 * N + 2 + TO + 1);
      check("to_idle", busy, 0);
      check("to_no_done_wr", nd + nw, 0);
      repeat (3) @(negedge clk);
      check("to_sticky", err, 1);
      kill = 0;
      fill(8'($urandom_range(255, 0)));
      run_frame($urandom_range(6, 1), 0);
      check("err_cleared", err, 0);
    end

    // Abort in STATS at rd_addr 0x05
    begin
      int cyc = 1, nd = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      while (!(rd_en && rd_addr == 8'h05) && cyc < 100) begin @(negedge clk); cyc++; end
      check("abort_reach", cyc, 6);
      abort = 1;
      @(negedge clk);
      abort = 0;
      check("abort_outs", {rd_en, busy, dp_valid}, 0);
      repeat (20) begin @(negedge clk); nd += done + wr_en + busy; end
      check("abort_quiet", nd, 0);
    end

    // A couple of fully random frames
    repeat (2) begin
      fill(8'($urandom_range(255, 0)));
      run_frame($urandom_range(6, 1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
